mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

MEM/WB pipeline register and write-back stage of the five-stage MIPS core. It registers the MEM-stage result under stall and flush control. It aligns and sign- or zero-extends load data returned by the synchronous data memory, and it drives the register file's write port (`wb_we`, `wb_waddr`, `wb_wdata`) and the HI/LO write port. The write-back outputs also feed the ID-stage forwarding logic.

## Interface
- No parameters. Widths are fixed by the core: 32-bit data, 5-bit register address.
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `mem_stall`  in  1  MEM stage stalled this cycle.
- `wb_stall`  in  1  WB stage stalled this cycle.
- `flush`  in  1  exception flush; kills the instruction being captured.
- `mem_we`  in  1  MEM instruction writes a GPR.
- `mem_waddr`  in  5  destination GPR.
- `mem_wdata`  in  32  ALU/move result; used when not a load.
- `mem_is_load`  in  1  MEM instruction is a load.
- `mem_load_op`  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5–7 treated as LW.
- `mem_addr_lo`  in  2  low two bits of the load address.
- `mem_whilo`, `mem_hi`, `mem_lo`  in  1/32/32  HI/LO write request and data.
- `dmem_rdata`  in  32  data-memory read word; valid in the first cycle the load is in WB.
- `wb_we`  out  1  GPR write enable to the register file.
- `wb_waddr`  out  5  GPR write address.
- `wb_wdata`  out  32  GPR write data.
- `wb_whilo`, `wb_hi`, `wb_lo`  out  1/32/32  HI/LO write port.

## Operation
- **Stage register** holds: we, waddr, wdata, is_load, load_op, addr_lo, whilo, hi, lo.
- **Update priority**, evaluated each rising edge:
  1. `rst`: all fields cleared.
  2. `flush`: all fields cleared (bubble).
  3. `mem_stall` && !`wb_stall`: bubble; we, whilo and is_load cleared, other fields don't-care.
  4. !`mem_stall`: capture the MEM inputs.
  5. Otherwise (both stalled): hold.
- **Load hold register** `ld_buf` (32 bit) with flag `ld_valid`:
  - In the first WB cycle of a load, `dmem_rdata` is used directly.
  - If `wb_stall` is high in that cycle, `dmem_rdata` is captured into `ld_buf` and `ld_valid` is set.
  - While `ld_valid` is set, the word comes from `ld_buf`.
  - `ld_valid` is cleared on any stage-register update (capture, bubble or flush) and on `rst`.
- **Raw load word** W = `ld_valid` ? `ld_buf` : `dmem_rdata`.
- **Alignment** is big-endian:
  - Byte select: `addr_lo`=0 → W[31:24], 1 → W[23:16], 2 → W[15:8], 3 → W[7:0].
  - Half select: `addr_lo[1]`=0 → W[31:16], 1 → W[15:0]; `addr_lo[0]` is ignored (misalignment is trapped upstream).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes W unchanged.
- **Outputs:**
  - `wb_we` and `wb_waddr` come from the register.
  - `wb_wdata` = is_load ? aligned load : registered wdata, forced to 0 when `wb_we`=0.
  - `wb_whilo`, `wb_hi` and `wb_lo` come from the register; `wb_hi` and `wb_lo` are forced to 0 when `wb_whilo`=0.
- `waddr`=0 with we=1 is passed through unchanged; the register file suppresses the write.

## Timing
- MEM to WB latency is one cycle. `wb_*` outputs are valid in the cycle after capture.
- `wb_wdata` is combinational from the register, `ld_buf` and `dmem_rdata`. There is no extra cycle, and the register file write lands on the next edge.
- Reset value of every output is 0. `ld_valid`=0 after reset.
- A held instruction presents identical outputs every stalled cycle, including load data after `dmem_rdata` changes.
- Simultaneous events:
  - `flush` overrides both stalls.
  - `rst` overrides everything.
  - `rst` or `flush` mid-stall discards the held instruction and `ld_buf`.
- The register is never written from `wb_*`. There is no WB-to-MEM feedback path.

## Test plan
- Reset with random inputs → all outputs 0; after release, capture `mem_we`=1, `waddr`=5, `wdata`=0x1234_5678 → next cycle `wb_we`=1, `wb_waddr`=5, `wb_wdata`=0x1234_5678.
- Loads with `dmem_rdata`=0x80F1_7F02:
  - LB, `addr_lo`=0 → 0xFFFF_FF80.
  - LBU, `addr_lo`=1 → 0x0000_00F1.
  - LH, `addr_lo`=2 → 0x0000_7F02.
  - LHU, `addr_lo`=0 → 0x0000_80F1.
  - LW → 0x80F1_7F02.
- `mem_stall`=1, `wb_stall`=0 for 2 cycles → `wb_we`=0 both cycles; releasing the stall captures the next instruction normally.
- LB `addr_lo`=3 with `dmem_rdata`=0x0000_00AA, then `wb_stall`=1 for 3 cycles while `dmem_rdata` changes to 0 → `wb_wdata` stays 0xFFFF_FFAA throughout.
- `flush`=1 together with `mem_stall`=`wb_stall`=1 while a write is held → next cycle `wb_we`=0, `wb_whilo`=0, `wb_wdata`=0.
- `mem_whilo`=1, hi=0xDEAD_BEEF, lo=0x0000_0001 → next cycle `wb_whilo`=1 with matching values; a following bubble gives `wb_hi`=`wb_lo`=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage: stage register with stall/flush
// control, big-endian load alignment/extension, GPR and HI/LO write-back ports.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  logic        wb_stall,
    input  logic        flush,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_op,
    input  logic [1:0]  mem_addr_lo,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [31:0] dmem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo
);

    typedef enum logic [2:0] {
        LD_W   = 3'd0,
        LD_B   = 3'd1,
        LD_BU  = 3'd2,
        LD_H   = 3'd3,
        LD_HU  = 3'd4
    } load_op_t;

    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic        r_is_load;
    logic [2:0]  r_load_op;
    logic [1:0]  r_addr_lo;
    logic        r_whilo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_ld_buf;
    logic        r_ld_valid;

    logic        w_hold;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Only the both-stalled case leaves the stage register untouched.
    assign w_hold = mem_stall && wb_stall;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_is_load <= 1'b0;
            r_load_op <= '0;
            r_addr_lo <= '0;
            r_whilo   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (mem_stall && !wb_stall) begin
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
            r_whilo   <= 1'b0;
        end else if (!mem_stall) begin
            r_we      <= mem_we;
            r_waddr   <= mem_waddr;
            r_wdata   <= mem_wdata;
            r_is_load <= mem_is_load;
            r_load_op <= mem_load_op;
            r_addr_lo <= mem_addr_lo;
            r_whilo   <= mem_whilo;
            r_hi      <= mem_hi;
            r_lo      <= mem_lo;
        end
    end

    // Memory word is only valid in the first WB cycle; keep it for stalled cycles.
    always_ff @(posedge clk) begin
        if (rst || flush || !w_hold) begin
            r_ld_valid <= 1'b0;
            r_ld_buf   <= '0;
        end else if (r_is_load && !r_ld_valid) begin
            r_ld_valid <= 1'b1;
            r_ld_buf   <= dmem_rdata;
        end
    end

    assign w_word = r_ld_valid ? r_ld_buf : dmem_rdata;

    always_comb begin
        w_byte = '0;
        case (r_addr_lo)
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
        w_half = r_addr_lo[1] ? w_word[15:0] : w_word[31:16];
    end

    always_comb begin
        w_load = w_word;
        case (load_op_t'(r_load_op))
            LD_B:    w_load = {{24{w_byte[7]}}, w_byte};
            LD_BU:   w_load = {24'd0, w_byte};
            LD_H:    w_load = {{16{w_half[15]}}, w_half};
            LD_HU:   w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    assign wb_we    = r_we;
    assign wb_waddr = r_waddr;
    assign wb_wdata = r_we ? (r_is_load ? w_load : r_wdata) : '0;
    assign wb_whilo = r_whilo;
    assign wb_hi    = r_whilo ? r_hi : '0;
    assign wb_lo    = r_whilo ? r_lo : '0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_stall, wb_stall, flush;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_is_load;
    logic [2:0]  mem_load_op;
    logic [1:0]  mem_addr_lo;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic [31:0] dmem_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;

    int unsigned total = 0;
    int unsigned bad   = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .mem_stall(mem_stall), .wb_stall(wb_stall), .flush(flush),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_is_load(mem_is_load), .mem_load_op(mem_load_op), .mem_addr_lo(mem_addr_lo),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .dmem_rdata(dmem_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        mem_we = we; mem_waddr = wa; mem_wdata = wd;
        mem_is_load = 1'b0; mem_load_op = 3'd0; mem_addr_lo = 2'd0;
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] lo,
                           input logic [31:0] mem_word, input logic [31:0] exp);
        mem_we = 1'b1; mem_waddr = 5'd9; mem_wdata = 32'hCAFE_0000;
        mem_is_load = 1'b1; mem_load_op = op; mem_addr_lo = lo;
        step();
        dmem_rdata = mem_word;
        #1;
        chk(tag, wb_wdata, exp);
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        mem_stall = 1'($urandom); wb_stall = 1'($urandom); flush = 1'($urandom);
        mem_we = 1'($urandom); mem_waddr = 5'($urandom); mem_wdata = $urandom;
        mem_is_load = 1'($urandom); mem_load_op = 3'($urandom); mem_addr_lo = 2'($urandom);
        mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
        dmem_rdata = $urandom;
        step();
        step();
        chk("rst_we",    32'(wb_we),    32'h0);
        chk("rst_waddr", 32'(wb_waddr), 32'h0);
        chk("rst_wdata", wb_wdata,      32'h0);
        chk("rst_whilo", 32'(wb_whilo), 32'h0);
        chk("rst_hi",    wb_hi,         32'h0);
        chk("rst_lo",    wb_lo,         32'h0);

        // Basic capture
        rst = 1'b0; mem_stall = 1'b0; wb_stall = 1'b0; flush = 1'b0;
        set_alu(1'b1, 5'd5, 32'h1234_5678);
        step();
        chk("cap_we",    32'(wb_we),    32'h1);
        chk("cap_waddr", 32'(wb_waddr), 32'd5);
        chk("cap_wdata", wb_wdata,      32'h1234_5678);

        // Load alignment / extension
        do_load("lb_0",  3'd1, 2'd0, 32'h80F1_7F02, 32'hFFFF_FF80);
        do_load("lbu_1", 3'd2, 2'd1, 32'h80F1_7F02, 32'h0000_00F1);
        do_load("lh_2",  3'd3, 2'd2, 32'h80F1_7F02, 32'h0000_7F02);
        do_load("lhu_0", 3'd4, 2'd0, 32'h80F1_7F02, 32'h0000_80F1);
        do_load("lw",    3'd0, 2'd0, 32'h80F1_7F02, 32'h80F1_7F02);
        do_load("lb_2",  3'd1, 2'd2, 32'h80F1_7F02, 32'h0000_007F);
        do_load("lh_3",  3'd3, 2'd3, 32'h80F1_7F02, 32'h0000_7F02);
        do_load("lhu_2", 3'd4, 2'd2, 32'h0000_8001, 32'h0000_8001);
        do_load("op7lw", 3'd7, 2'd1, 32'h80F1_7F02, 32'h80F1_7F02);

        // MEM stall bubbles
        set_alu(1'b1, 5'd6, 32'h5555_AAAA);
        mem_stall = 1'b1;
        step();
        chk("bub1_we", 32'(wb_we), 32'h0);
        chk("bub1_wd", wb_wdata,   32'h0);
        step();
        chk("bub2_we", 32'(wb_we), 32'h0);
        mem_stall = 1'b0;
        set_alu(1'b1, 5'd7, 32'h0000_A5A5);
        step();
        chk("rel_we",    32'(wb_we),    32'h1);
        chk("rel_waddr", 32'(wb_waddr), 32'd7);
        chk("rel_wdata", wb_wdata,      32'h0000_A5A5);

        // Write to r0 passes through
        set_alu(1'b1, 5'd0, 32'h0BAD_F00D);
        step();
        chk("r0_we",    32'(wb_we), 32'h1);
        chk("r0_wdata", wb_wdata,   32'h0BAD_F00D);

        // Load held across WB stall while memory data changes
        do_load("lb_3", 3'd1, 2'd3, 32'h0000_00AA, 32'hFFFF_FFAA);
        mem_stall = 1'b1; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            dmem_rdata = 32'h0;
            #1;
            chk("ldhold_wd", wb_wdata,   32'hFFFF_FFAA);
            chk("ldhold_we", 32'(wb_we), 32'h1);
        end

        // Stall release: new load must use fresh memory data, not the buffer
        mem_stall = 1'b0; wb_stall = 1'b0;
        do_load("ld_fresh", 3'd0, 2'd0, 32'h1122_3344, 32'h1122_3344);

        // Held write with HI/LO, then flush during both stalls
        set_alu(1'b1, 5'd12, 32'h7777_8888);
        mem_whilo = 1'b1; mem_hi = 32'h0000_00F0; mem_lo = 32'h0000_000F;
        step();
        mem_stall = 1'b1; wb_stall = 1'b1;
        step();
        chk("held_wd", wb_wdata, 32'h7777_8888);
        chk("held_hi", wb_hi,    32'h0000_00F0);
        flush = 1'b1;
        step();
        chk("fl_we",    32'(wb_we),    32'h0);
        chk("fl_whilo", 32'(wb_whilo), 32'h0);
        chk("fl_wdata", wb_wdata,      32'h0);
        chk("fl_hi",    wb_hi,         32'h0);

        // HI/LO write then bubble
        flush = 1'b0; mem_stall = 1'b0; wb_stall = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);
        mem_whilo = 1'b1; mem_hi = 32'hDEAD_BEEF; mem_lo = 32'h0000_0001;
        step();
        chk("hl_whilo", 32'(wb_whilo), 32'h1);
        chk("hl_hi",    wb_hi,         32'hDEAD_BEEF);
        chk("hl_lo",    wb_lo,         32'h0000_0001);
        chk("hl_we",    32'(wb_we),    32'h0);
        mem_stall = 1'b1;
        step();
        chk("hlb_whilo", 32'(wb_whilo), 32'h0);
        chk("hlb_hi",    wb_hi,         32'h0);
        chk("hlb_lo",    wb_lo,         32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
